phys_free_list: RTL and testbench

- Circular FIFO of free physical register numbers.
- Serves the rename/dispatch stage: it supplies `phys_reg` and `is_free_list_empty`, and consumes `dequeue_free_list`.
- Accepts freed (stale) physical registers from the ROB commit stage.
- On a branch-mispredict flush it restores itself to the full, architecturally consistent state in one cycle.

---
 rtl/phys_free_list.sv | 72 +++++++
 tb/tb_phys_free_list.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register numbers feeding rename.
// Restores to the full, architecturally consistent state in one cycle on flush.
module phys_free_list #(
    parameter int unsigned PHYS_REG_BITS = 6,
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    localparam int unsigned DEPTH        = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned PTR_BITS     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dequeue,
    output logic [PHYS_REG_BITS-1:0] phys_reg,
    output logic                     is_free_list_empty,
    output logic                     is_free_list_full,
    input  logic                     enqueue,
    input  logic [PHYS_REG_BITS-1:0] enqueue_reg,
    input  logic                     flush,
    output logic [PTR_BITS:0]        free_count
);

    localparam logic [PTR_BITS:0] DepthCnt = (PTR_BITS + 1)'(DEPTH);

    logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0]      head_q, head_d;
    logic [PTR_BITS-1:0]      tail_q, tail_d;
    logic [PTR_BITS:0]        count_q, count_d;
    logic                     deq_eff;
    logic                     enq_eff;

    assign phys_reg           = mem_q[head_q];
    assign is_free_list_empty = (count_q == '0);
    assign is_free_list_full  = (count_q == DepthCnt);
    assign free_count         = count_q;

    always_comb begin
        deq_eff = dequeue && !is_free_list_empty && !flush;
        enq_eff = enqueue && (enqueue_reg != '0) && !is_free_list_full;
        tail_d  = tail_q + PTR_BITS'(enq_eff);
        head_d  = head_q + PTR_BITS'(deq_eff);
        count_d = count_q + (PTR_BITS + 1)'(enq_eff) - (PTR_BITS + 1)'(deq_eff);
        // The DEPTH slots behind tail are exactly the regs not held by the retirement RAT.
        if (flush) begin
            head_d  = tail_d;
            count_d = DepthCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DepthCnt;
        end else begin
            if (enq_eff) begin
                mem_q[tail_q] <= enqueue_reg;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Commit should never return a register while every slot is already free.
    assert property (@(posedge clk) disable iff (!rst)
                     !(enqueue && (enqueue_reg != '0) && is_free_list_full))
        else $warning("enqueue into full free list dropped");

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: vector table plus hand-built sequences,
// with expected outputs queued at drive time and compared after the clock edge.
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       dequeue;
    logic [5:0] phys_reg;
    logic       is_free_list_empty;
    logic       is_free_list_full;
    logic       enqueue;
    logic [5:0] enqueue_reg;
    logic       flush;
    logic [5:0] free_count;

    int n_assert = 0;
    int n_fail   = 0;

    phys_free_list dut (
        .clk               (clk),
        .rst               (rst),
        .dequeue           (dequeue),
        .phys_reg          (phys_reg),
        .is_free_list_empty(is_free_list_empty),
        .is_free_list_full (is_free_list_full),
        .enqueue           (enqueue),
        .enqueue_reg       (enqueue_reg),
        .flush             (flush),
        .free_count        (free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       deq;
        logic       enq;
        logic [5:0] ereg;
        logic       flush;
        logic [5:0] phys;
        logic       empty;
        logic       full;
        logic [5:0] cnt;
        string      name;
    } vec_t;

    typedef struct {
        logic [5:0] phys;
        logic       empty;
        logic       full;
        logic [5:0] cnt;
        string      name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare after the edge.
    task automatic step(input logic r, input logic d, input logic e, input logic [5:0] er,
                        input logic f, input logic [5:0] ep, input logic ee,
                        input logic ef, input logic [5:0] ec, input string name);
        exp_t x;
        @(negedge clk);
        rst = r; dequeue = d; enqueue = e; enqueue_reg = er; flush = f;
        sb.push_back('{phys: ep, empty: ee, full: ef, cnt: ec, name: name});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.name, " free_count"}, 32'(free_count), 32'(x.cnt));
        chk({x.name, " empty"}, 32'(is_free_list_empty), 32'(x.empty));
        chk({x.name, " full"}, 32'(is_free_list_full), 32'(x.full));
        if (!x.empty) chk({x.name, " phys_reg"}, 32'(phys_reg), 32'(x.phys));
    endtask

    vec_t tbl[17];
    int   order[32];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; dequeue = 1'b0; enqueue = 1'b0; enqueue_reg = '0; flush = 1'b0;

        //          rst deq enq ereg flush phys emp full cnt
        tbl[0]  = '{0, 0, 0, 6'd0,  0, 6'd32, 0, 1, 6'd32, "reset"};
        tbl[1]  = '{0, 0, 0, 6'd0,  0, 6'd32, 0, 1, 6'd32, "reset_hold"};
        tbl[2]  = '{1, 0, 1, 6'd0,  0, 6'd32, 0, 1, 6'd32, "enq_p0_full"};
        tbl[3]  = '{1, 0, 1, 6'd7,  0, 6'd32, 0, 1, 6'd32, "enq_when_full"};
        tbl[4]  = '{1, 1, 0, 6'd0,  0, 6'd33, 0, 0, 6'd31, "deq1"};
        tbl[5]  = '{1, 0, 1, 6'd0,  0, 6'd33, 0, 0, 6'd31, "enq_p0"};
        tbl[6]  = '{1, 1, 1, 6'd45, 0, 6'd34, 0, 0, 6'd31, "deq_enq45"};
        tbl[7]  = '{1, 0, 0, 6'd0,  1, 6'd33, 0, 1, 6'd32, "flush_reclaim"};
        tbl[8]  = '{0, 0, 0, 6'd0,  0, 6'd32, 0, 1, 6'd32, "reset2"};
        tbl[9]  = '{1, 1, 0, 6'd0,  0, 6'd33, 0, 0, 6'd31, "spec_deq32"};
        tbl[10] = '{1, 1, 0, 6'd0,  0, 6'd34, 0, 0, 6'd30, "spec_deq33"};
        tbl[11] = '{1, 1, 0, 6'd0,  0, 6'd35, 0, 0, 6'd29, "spec_deq34"};
        tbl[12] = '{1, 1, 0, 6'd0,  0, 6'd36, 0, 0, 6'd28, "spec_deq35"};
        tbl[13] = '{1, 1, 0, 6'd0,  0, 6'd37, 0, 0, 6'd27, "spec_deq36"};
        tbl[14] = '{1, 1, 0, 6'd0,  1, 6'd32, 0, 1, 6'd32, "flush_with_deq"};
        tbl[15] = '{1, 1, 0, 6'd0,  0, 6'd33, 0, 0, 6'd31, "pre_reset_deq"};
        tbl[16] = '{0, 1, 1, 6'd9,  0, 6'd32, 0, 1, 6'd32, "mid_reset"};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].deq, tbl[i].enq, tbl[i].ereg, tbl[i].flush,
                 tbl[i].phys, tbl[i].empty, tbl[i].full, tbl[i].cnt, tbl[i].name);
        end

        // Drain all 32, then a dequeue on empty, then enqueue into empty with dequeue.
        for (int k = 0; k < 32; k++) begin
            step(1, 1, 0, 0, 0, 6'(33 + k), (k == 31), 0, 6'(31 - k), "drain");
        end
        step(1, 1, 0, 0, 0, 6'd0, 1, 0, 6'd0, "deq_empty");
        step(1, 1, 1, 6'd40, 0, 6'd40, 0, 0, 6'd1, "enq40_empty");
        step(1, 1, 0, 0, 0, 6'd0, 1, 0, 6'd0, "deq40");

        // Wrap: 45 written at slot 0 must follow 63.
        step(0, 0, 0, 0, 0, 6'd32, 0, 1, 6'd32, "reset3");
        step(1, 1, 0, 0, 0, 6'd33, 0, 0, 6'd31, "wrap_deq");
        step(1, 1, 1, 6'd45, 0, 6'd34, 0, 0, 6'd31, "wrap_deq_enq45");
        for (int n = 1; n <= 30; n++) begin
            step(1, 1, 0, 0, 0, (n == 30) ? 6'd45 : 6'(34 + n), 0, 0, 6'(31 - n), "wrap");
        end
        step(1, 1, 0, 0, 0, 6'd0, 1, 0, 6'd0, "wrap_empty");

        // Flush with a same-cycle enqueue after 3 dequeues and enqueues of 51, 52.
        step(0, 0, 0, 0, 0, 6'd32, 0, 1, 6'd32, "reset4");
        step(1, 1, 0, 0, 0, 6'd33, 0, 0, 6'd31, "fl_deq0");
        step(1, 1, 0, 0, 0, 6'd34, 0, 0, 6'd30, "fl_deq1");
        step(1, 1, 0, 0, 0, 6'd35, 0, 0, 6'd29, "fl_deq2");
        step(1, 0, 1, 6'd51, 0, 6'd35, 0, 0, 6'd30, "fl_enq51");
        step(1, 0, 1, 6'd52, 0, 6'd35, 0, 0, 6'd31, "fl_enq52");
        step(1, 1, 1, 6'd50, 1, 6'd35, 0, 1, 6'd32, "flush_enq50");
        for (int i = 0; i < 29; i++) order[i] = 35 + i;
        order[29] = 51; order[30] = 52; order[31] = 50;
        for (int i = 0; i < 32; i++) begin
            step(1, 1, 0, 0, 0, (i == 31) ? 6'd0 : 6'(order[i + 1]), (i == 31), 0,
                 6'(31 - i), "post_flush_order");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
